// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants: receiver FSM states,
//            oversampling factor and prescale counter width / helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // One bit period is prescale * UART_OVERSAMPLE clocks.
  localparam int UART_OVERSAMPLE      = 8;
  localparam int UART_OVERSAMPLE_LOG2 = $clog2(UART_OVERSAMPLE);

  // Wide enough to hold (prescale << 3) without truncation.
  localparam int UART_PRESCALE_CNT_W = 19;

  typedef logic [UART_PRESCALE_CNT_W-1:0] uart_cnt_t;

  // Down-counter load value that expires after (p << shamt) clocks.
  function automatic uart_cnt_t uart_ticks(input logic [15:0] p, input int shamt);
    return (uart_cnt_t'(p) << shamt) - uart_cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchronizer for an idle-high asynchronous line.
//            Both stages reset to 1 so a reset never looks like a start bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver (start, DATA_WIDTH data LSB first,
//            stop) with AXI4-Stream master output, framing-error and overrun
//            pulses. Bit period = prescale*8 clocks, prescale latched at
//            start-bit detection.
//            Build option UART_RX_SYNC_EN: route rxd through a 2-flop
//            synchronizer (adds 2 cycles of latency to all sample points).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  import uart_pkg::*;

  logic rxs;

`ifdef UART_RX_SYNC_EN
  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );
`else
  assign rxs = rxd;
`endif

  uart_state_t           state, state_nxt;
  uart_cnt_t             cnt, cnt_nxt;
  logic [15:0]           p_lat, p_lat_nxt;
  logic [3:0]            bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DATA_WIDTH-1:0] tdata_nxt;
  logic                  tvalid_nxt;
  logic                  ovr_nxt;
  logic                  fe_nxt;
  logic                  tick;

  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  // Next-state, counters, shift register and output register values.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    p_lat_nxt   = p_lat;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tdata_nxt   = m_axis_tdata;
    tvalid_nxt  = m_axis_tvalid & ~m_axis_tready;
    ovr_nxt     = 1'b0;
    fe_nxt      = 1'b0;

    if (state != IDLE && !tick) begin
      cnt_nxt = cnt - uart_cnt_t'(1);
    end

    case (state)
      IDLE: begin
        // A zero prescale would give no usable bit timing; ignore the line.
        if (!rxs && prescale != 16'd0) begin
          p_lat_nxt = prescale;
          cnt_nxt   = uart_ticks(prescale, UART_OVERSAMPLE_LOG2 - 1);
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rxs) begin
            cnt_nxt     = uart_ticks(p_lat, UART_OVERSAMPLE_LOG2);
            bit_cnt_nxt = 4'(DATA_WIDTH);
            state_nxt   = DATA;
          end else begin
            // Line went high before mid-start-bit: glitch, drop silently.
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt   = {rxs, shreg[DATA_WIDTH-1:1]};
          bit_cnt_nxt = bit_cnt - 4'd1;
          cnt_nxt     = uart_ticks(p_lat, UART_OVERSAMPLE_LOG2);
          if (bit_cnt == 4'd1) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so the next start edge has half a bit of slack.
        if (tick) begin
          state_nxt = IDLE;
          if (rxs) begin
            tdata_nxt  = shreg;
            tvalid_nxt = 1'b1;
            ovr_nxt    = m_axis_tvalid & ~m_axis_tready;
          end else begin
            fe_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      p_lat         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      p_lat         <= p_lat_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shreg         <= shreg_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
      overrun_error <= ovr_nxt;
      frame_error   <= fe_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: directed frames plus randomized
//            frames checked against a transaction-level model of the output
//            stream (pending word, overrun and framing-error rules).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DW = 8;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic          clk           = 1'b0;
  logic          rst_n         = 1'b0;
  logic          rxd           = 1'b1;
  logic          m_axis_tready = 1'b0;
  logic [15:0]   prescale      = 16'd1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          busy;
  logic          overrun_error;
  logic          frame_error;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int e0;

  // Model of the stream output: one pending word slot.
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data  = '0;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the edge that makes cyc == t.
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one frame of d at prescale p, then check the outputs at the stop
  // sample and one cycle later against the model.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_ok, input int p,
                            input logic rdy, input logic late_rdy);
    int   e, s;
    logic hs, exp_ovr, exp_fe;
    prescale      = 16'(p);
    m_axis_tready = late_rdy ? 1'b0 : rdy;
    rxd           = 1'b0;
    e             = cyc;
    if (m_axis_tready && exp_valid) exp_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      wait_until(e + 8*p*(i+1));
      rxd = d[i];
      // Latched prescale must be unaffected by a mid-frame change.
      if (i == 0) prescale = 16'($urandom_range(1, 5));
    end
    wait_until(e + 8*p*(DW+1));
    rxd = stop_ok;
    s = e + 1 + 4*p + 8*p*(DW+1) + SYNC;
    if (SYNC > 0) begin
      wait_until(s - SYNC);
      rxd = 1'b1;
    end
    wait_until(s - 1);
    chk("busy_before_stop", busy, 1);
    if (late_rdy) m_axis_tready = 1'b1;
    wait_until(s);
    rxd     = 1'b1;
    hs      = exp_valid && m_axis_tready;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    if (stop_ok) begin
      exp_ovr   = exp_valid && !hs;
      exp_data  = d;
      exp_valid = 1'b1;
    end else begin
      exp_fe = 1'b1;
      if (hs) exp_valid = 1'b0;
    end
    chk("stop_tvalid", m_axis_tvalid, exp_valid);
    chk("stop_tdata", m_axis_tdata, exp_data);
    chk("stop_overrun", overrun_error, exp_ovr);
    chk("stop_frame_err", frame_error, exp_fe);
    chk("stop_busy", busy, 0);
    wait_until(s + 1);
    if (exp_valid && m_axis_tready) exp_valid = 1'b0;
    chk("after_tvalid", m_axis_tvalid, exp_valid);
    chk("after_tdata", m_axis_tdata, exp_data);
    chk("after_overrun", overrun_error, 0);
    chk("after_frame_err", frame_error, 0);
    wait_until(e + 8*p*(DW+2));
  endtask

  // Directed and randomized stimulus.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_error, 0);
    chk("rst_frame_err", frame_error, 0);
    rst_n = 1'b1;
    wait_until(cyc + 4);

    // Basic frame, downstream always ready.
    send_frame(8'hA5, 1'b1, 1, 1'b1, 1'b0);

    // Two frames without acceptance: second one overruns.
    send_frame(8'h3C, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1, 1'b0, 1'b0);

    // Drain, then a frame with a low stop bit.
    m_axis_tready = 1'b1;
    wait_until(cyc + 1);
    exp_valid = 1'b0;
    chk("drain_tvalid", m_axis_tvalid, 0);
    send_frame(8'h55, 1'b0, 2, 1'b1, 1'b0);

    // Short low pulse (3 cycles at prescale 1) is a glitch.
    m_axis_tready = 1'b0;
    prescale      = 16'd1;
    rxd           = 1'b0;
    e0            = cyc;
    wait_until(e0 + 3);
    rxd = 1'b1;
    wait_until(e0 + 4 + SYNC);
    chk("glitch_busy_up", busy, 1);
    wait_until(e0 + 5 + SYNC);
    chk("glitch_busy_down", busy, 0);
    chk("glitch_frame_err", frame_error, 0);
    chk("glitch_overrun", overrun_error, 0);
    chk("glitch_tvalid", m_axis_tvalid, exp_valid);
    wait_until(cyc + 6);

    // Zero prescale: line activity ignored.
    prescale = 16'd0;
    rxd      = 1'b0;
    e0       = cyc;
    wait_until(e0 + 20);
    chk("p0_busy_low", busy, 0);
    rxd = 1'b1;
    wait_until(e0 + 24);
    chk("p0_busy_idle", busy, 0);

    // Completion in the same cycle the previous word is accepted.
    send_frame(DW'($urandom), 1'b1, 1, 1'b0, 1'b0);
    send_frame(DW'($urandom), 1'b1, 1, 1'b0, 1'b1);

    // Leave a word pending, then reset in the middle of a frame.
    send_frame(DW'($urandom), 1'b1, 1, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    prescale      = 16'd1;
    rxd           = 1'b0;
    e0            = cyc;
    wait_until(e0 + 20);
    rxd = 1'b1;
    wait_until(e0 + 30);
    rxd = 1'b0;
    wait_until(e0 + 33);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_tdata", m_axis_tdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun_error, 0);
    chk("arst_frame_err", frame_error, 0);
    rxd = 1'b1;
    @(posedge clk);
    #1;
    wait_until(cyc + 3);
    chk("arst_hold_tvalid", m_axis_tvalid, 0);
    rst_n     = 1'b1;
    exp_valid = 1'b0;
    exp_data  = '0;
    wait_until(cyc + 5);
    send_frame(8'h0F, 1'b1, 1, 1'b1, 1'b0);

    // Randomized frames.
    for (int k = 0; k < 10; k++) begin
      send_frame(DW'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
